// File: rtl/axi_mem_arbiter_pkg.sv
// rtl/axi_mem_arbiter_pkg.sv - shared types and AXI constants for axi_mem_arbiter
package axi_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        AW_W,
        B,
        RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // 0 = instruction port, 1 = data port
    typedef logic port_idx_t;

    // AXI size encoding for a full-width beat
    function automatic logic [2:0] axi_size(input int unsigned data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/axi_bus.sv
// rtl/axi_bus.sv - AXI4 bus interface with master and slave views
// Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH.
// Channels: aw, w, b, ar, r with valid/ready handshakes.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 16,
    parameter int unsigned AXI_USER_WIDTH = 10
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
        input b_id, b_resp, b_user, b_valid, output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
        input r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
    );

    modport Slave (
        input aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
        input w_data, w_strb, w_last, w_user, w_valid, output w_ready,
        output b_id, b_resp, b_user, b_valid, input b_ready,
        input ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
    );

endinterface

// File: rtl/axi_mem_arbiter_sel.sv
// rtl/axi_mem_arbiter_sel.sv - 2-way request selector, round-robin or fixed priority
// Ports: clk_i/rst_ni clock and async active-low reset; req_i requests (already
// gated to grantable cycles); gnt_o one-hot grant; idx_o granted port index.
// Config: AXI_MEM_ARBITER_RR_EN selects round-robin; otherwise port 1 always wins.
module axi_mem_arbiter_sel
    import axi_mem_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output port_idx_t  idx_o
);

`ifdef AXI_MEM_ARBITER_RR_EN
    // Port served by the most recent grant; the other one wins a tie.
    port_idx_t last_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= 1'b0;
        end else if (|req_i) begin
            last_q <= idx_o;
        end
    end

    always_comb begin
        idx_o = req_i[1];
        if (req_i == 2'b11) begin
            idx_o = ~last_q;
        end
    end
`else
    logic unused_clk;
    assign unused_clk = clk_i ^ rst_ni;

    always_comb begin
        idx_o = req_i[1];
    end
`endif

    always_comb begin
        gnt_o = 2'b00;
        if (|req_i) begin
            gnt_o = idx_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/axi_mem_arbiter.sv
// rtl/axi_mem_arbiter.sv - two-port requester to single-beat AXI master arbiter
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/gnt_o request and
// one-hot grant per port; addr_i/we_i/be_i/wdata_i transaction fields per port;
// rvalid_o/rdata_o/err_o completion pulse, read data, error; AXI_Master bus.
// Config: AXI_MEM_ARBITER_RR_EN enables round-robin tie breaking.
module axi_mem_arbiter
    import axi_mem_arbiter_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 16,
    parameter int unsigned AXI_USER_WIDTH = 10
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [1:0]                         req_i,
    output logic [1:0]                         gnt_o,
    input  logic [1:0][AXI_ADDR_WIDTH-1:0]     addr_i,
    input  logic [1:0]                         we_i,
    input  logic [1:0][AXI_DATA_WIDTH/8-1:0]   be_i,
    input  logic [1:0][AXI_DATA_WIDTH-1:0]     wdata_i,
    output logic [1:0]                         rvalid_o,
    output logic [AXI_DATA_WIDTH-1:0]          rdata_o,
    output logic                               err_o,
    AXI_BUS.Master                             AXI_Master
);

    localparam int unsigned OFFS     = $clog2(AXI_DATA_WIDTH / 8);
    localparam logic [2:0]  AXI_SIZE = axi_size(AXI_DATA_WIDTH);

    state_e                      state_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [AXI_DATA_WIDTH/8-1:0] be_q;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q;
    port_idx_t                   port_q;
    logic                        ar_valid_q, aw_valid_q, w_valid_q;
    logic                        r_ready_q, b_ready_q;
    logic [1:0]                  rvalid_q;
    logic                        err_q;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q;

    logic                        idle;
    logic [1:0]                  sel_req, sel_gnt;
    port_idx_t                   sel_idx;
    logic [AXI_ADDR_WIDTH-1:0]   addr_aligned;

    // Grants only in IDLE and never while reset is held.
    assign idle    = (state_q == IDLE) && rst_ni;
    assign sel_req = req_i & {2{idle}};

    axi_mem_arbiter_sel u_sel (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (sel_req),
        .gnt_o  (sel_gnt),
        .idx_o  (sel_idx)
    );

    assign gnt_o = sel_gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            port_q     <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            r_ready_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            rvalid_q   <= 2'b00;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rvalid_q <= 2'b00;
            unique case (state_q)
                IDLE: begin
                    if (|sel_gnt) begin
                        addr_q  <= addr_i[sel_idx];
                        be_q    <= be_i[sel_idx];
                        wdata_q <= wdata_i[sel_idx];
                        port_q  <= sel_idx;
                        if (we_i[sel_idx]) begin
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            state_q    <= AW_W;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= AR;
                        end
                    end
                end
                AR: begin
                    if (AXI_Master.ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= R;
                    end
                end
                AW_W: begin
                    // A dropped valid marks its channel as already accepted.
                    if (AXI_Master.aw_ready) aw_valid_q <= 1'b0;
                    if (AXI_Master.w_ready)  w_valid_q  <= 1'b0;
                    if ((!aw_valid_q || AXI_Master.aw_ready) &&
                        (!w_valid_q  || AXI_Master.w_ready)) begin
                        b_ready_q <= 1'b1;
                        state_q   <= B;
                    end
                end
                R: begin
                    if (AXI_Master.r_valid) begin
                        r_ready_q <= 1'b0;
                        rdata_q   <= AXI_Master.r_data;
                        err_q     <= (AXI_Master.r_resp != AXI_RESP_OKAY);
                        rvalid_q  <= port_q ? 2'b10 : 2'b01;
                        state_q   <= RESP;
                    end
                end
                B: begin
                    if (AXI_Master.b_valid) begin
                        b_ready_q <= 1'b0;
                        rdata_q   <= '0;
                        err_q     <= (AXI_Master.b_resp != AXI_RESP_OKAY);
                        rvalid_q  <= port_q ? 2'b10 : 2'b01;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;

    assign addr_aligned = {addr_q[AXI_ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};

    assign AXI_Master.ar_id    = AXI_ID_WIDTH'(port_q);
    assign AXI_Master.ar_addr  = addr_aligned;
    assign AXI_Master.ar_len   = 8'd0;
    assign AXI_Master.ar_size  = AXI_SIZE;
    assign AXI_Master.ar_burst = AXI_BURST_INCR;
    assign AXI_Master.ar_user  = AXI_USER_WIDTH'(0);
    assign AXI_Master.ar_valid = ar_valid_q;
    assign AXI_Master.r_ready  = r_ready_q;

    assign AXI_Master.aw_id    = AXI_ID_WIDTH'(port_q);
    assign AXI_Master.aw_addr  = addr_aligned;
    assign AXI_Master.aw_len   = 8'd0;
    assign AXI_Master.aw_size  = AXI_SIZE;
    assign AXI_Master.aw_burst = AXI_BURST_INCR;
    assign AXI_Master.aw_user  = AXI_USER_WIDTH'(0);
    assign AXI_Master.aw_valid = aw_valid_q;
    assign AXI_Master.w_data   = wdata_q;
    assign AXI_Master.w_strb   = be_q;
    assign AXI_Master.w_last   = 1'b1;
    assign AXI_Master.w_user   = AXI_USER_WIDTH'(0);
    assign AXI_Master.w_valid  = w_valid_q;
    assign AXI_Master.b_ready  = b_ready_q;

    logic unused_axi;
    assign unused_axi = ^{AXI_Master.r_id, AXI_Master.r_last, AXI_Master.r_user,
                          AXI_Master.b_id, AXI_Master.b_user, addr_q[OFFS-1:0]};

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb/tb_axi_mem_arbiter.sv - directed self-checking bench for axi_mem_arbiter
// Honours AXI_MEM_ARBITER_RR_EN for the expected arbitration order.
module tb_axi_mem_arbiter;
    import axi_mem_arbiter_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic [1:0][31:0]  addr;
    logic [1:0]        we;
    logic [1:0][3:0]   be;
    logic [1:0][31:0]  wdata;
    logic [1:0]        rvalid;
    logic [31:0]       rdata;
    logic              err;

    int n_cmp;
    int n_bad;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
              .AXI_ID_WIDTH(16), .AXI_USER_WIDTH(10)) axi ();

    axi_mem_arbiter dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .req_i      (req),
        .gnt_o      (gnt),
        .addr_i     (addr),
        .we_i       (we),
        .be_i       (be),
        .wdata_i    (wdata),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .AXI_Master (axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic slave_set(input logic arr, input logic rv, input logic [31:0] rd,
                             input logic awr, input logic wr, input logic bv,
                             input logic [1:0] br);
        axi.ar_ready = arr;
        axi.r_valid  = rv;
        axi.r_data   = rd;
        axi.r_resp   = AXI_RESP_OKAY;
        axi.aw_ready = awr;
        axi.w_ready  = wr;
        axi.b_valid  = bv;
        axi.b_resp   = br;
    endtask

    // Called at the negedge after the grant cycle; lat counts cycles from grant.
    task automatic wait_rvalid(output int lat);
        lat = 1;
        while (rvalid === 2'b00 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 2'b01;
        repeat (2) @(negedge clk);
        n_cmp++; if (gnt !== 2'b00) begin $display("FAIL reset_gnt: got %b want 00", gnt); n_bad++; end
        n_cmp++; if ({axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready} !== 5'b0) begin
            $display("FAIL reset_axi_valids: got %b want 00000",
                     {axi.ar_valid, axi.aw_valid, axi.w_valid, axi.r_ready, axi.b_ready}); n_bad++; end
        n_cmp++; if ({rvalid, err} !== 3'b000) begin $display("FAIL reset_rvalid_err: got %b want 000", {rvalid, err}); n_bad++; end
        n_cmp++; if (rdata !== 32'h0) begin $display("FAIL reset_rdata: got %h want 0", rdata); n_bad++; end
        req   = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int lat;
        slave_set(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, AXI_RESP_OKAY);
        addr[0] = 32'h0000_0104; we[0] = 1'b0; be[0] = 4'hF;
        req = 2'b01;
        #1;
        n_cmp++; if (gnt !== 2'b01) begin $display("FAIL read_gnt: got %b want 01", gnt); n_bad++; end
        @(negedge clk);
        req = 2'b00;
        n_cmp++; if (axi.ar_valid !== 1'b1) begin $display("FAIL read_ar_valid: got %b want 1", axi.ar_valid); n_bad++; end
        n_cmp++; if (axi.ar_addr !== 32'h104) begin $display("FAIL read_ar_addr: got %h want 104", axi.ar_addr); n_bad++; end
        n_cmp++; if (axi.ar_id !== 16'd0) begin $display("FAIL read_ar_id: got %h want 0", axi.ar_id); n_bad++; end
        n_cmp++; if ({axi.ar_len, axi.ar_size, axi.ar_burst} !== {8'd0, 3'd2, 2'b01}) begin
            $display("FAIL read_ar_fields: got %h/%h/%b want 0/2/01", axi.ar_len, axi.ar_size, axi.ar_burst); n_bad++; end
        wait_rvalid(lat);
        n_cmp++; if (lat !== 3) begin $display("FAIL read_latency: got %0d want 3", lat); n_bad++; end
        n_cmp++; if (rvalid !== 2'b01) begin $display("FAIL read_rvalid: got %b want 01", rvalid); n_bad++; end
        n_cmp++; if (rdata !== 32'hDEADBEEF) begin $display("FAIL read_rdata: got %h want deadbeef", rdata); n_bad++; end
        n_cmp++; if (err !== 1'b0) begin $display("FAIL read_err: got %b want 0", err); n_bad++; end
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b00) begin $display("FAIL read_rvalid_pulse: got %b want 00", rvalid); n_bad++; end
    endtask

    task automatic test_read_wait();
        slave_set(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, AXI_RESP_OKAY);
        addr[1] = 32'h0000_0107; we[1] = 1'b0; be[1] = 4'hF;
        req = 2'b10;
        #1;
        n_cmp++; if (gnt !== 2'b10) begin $display("FAIL rwait_gnt: got %b want 10", gnt); n_bad++; end
        @(negedge clk);
        req = 2'b00;
        n_cmp++; if ({axi.ar_addr, axi.ar_id} !== {32'h104, 16'd1}) begin
            $display("FAIL rwait_ar_addr_id: got %h/%h want 104/1", axi.ar_addr, axi.ar_id); n_bad++; end
        @(negedge clk);
        n_cmp++; if (axi.ar_valid !== 1'b1) begin $display("FAIL rwait_ar_hold: got %b want 1", axi.ar_valid); n_bad++; end
        axi.ar_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({axi.ar_valid, axi.r_ready} !== 2'b01) begin
            $display("FAIL rwait_in_r: got %b want 01", {axi.ar_valid, axi.r_ready}); n_bad++; end
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b00) begin $display("FAIL rwait_early_rvalid: got %b want 00", rvalid); n_bad++; end
        axi.r_valid = 1'b1; axi.r_data = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if ({rvalid, rdata} !== {2'b10, 32'h1234_5678}) begin
            $display("FAIL rwait_result: got %b/%h want 10/12345678", rvalid, rdata); n_bad++; end
        @(negedge clk);
    endtask

    task automatic test_single_write();
        slave_set(1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1, AXI_RESP_OKAY);
        addr[1] = 32'h0000_0200; we[1] = 1'b1; be[1] = 4'b0011; wdata[1] = 32'hCAFEF00D;
        req = 2'b10;
        #1;
        n_cmp++; if (gnt !== 2'b10) begin $display("FAIL write_gnt: got %b want 10", gnt); n_bad++; end
        @(negedge clk);
        req = 2'b00;
        n_cmp++; if ({axi.aw_valid, axi.w_valid, axi.ar_valid} !== 3'b110) begin
            $display("FAIL write_valids: got %b want 110", {axi.aw_valid, axi.w_valid, axi.ar_valid}); n_bad++; end
        n_cmp++; if ({axi.w_strb, axi.w_last} !== 5'b0011_1) begin
            $display("FAIL write_strb_last: got %b/%b want 0011/1", axi.w_strb, axi.w_last); n_bad++; end
        n_cmp++; if ({axi.w_data, axi.aw_addr, axi.aw_id} !== {32'hCAFEF00D, 32'h200, 16'd1}) begin
            $display("FAIL write_fields: got %h/%h/%h want cafef00d/200/1", axi.w_data, axi.aw_addr, axi.aw_id); n_bad++; end
        @(negedge clk);
        n_cmp++; if ({axi.aw_valid, axi.w_valid} !== 2'b10) begin
            $display("FAIL write_w_dropped: got %b want 10", {axi.aw_valid, axi.w_valid}); n_bad++; end
        @(negedge clk);
        axi.aw_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if ({axi.aw_valid, axi.b_ready, rvalid} !== 4'b0100) begin
            $display("FAIL write_in_b: got %b want 0100", {axi.aw_valid, axi.b_ready, rvalid}); n_bad++; end
        @(negedge clk);
        n_cmp++; if ({rvalid, rdata, err} !== {2'b10, 32'h0, 1'b0}) begin
            $display("FAIL write_result: got %b/%h/%b want 10/0/0", rvalid, rdata, err); n_bad++; end
        @(negedge clk);
    endtask

    task automatic test_write_error();
        int lat;
        slave_set(1'b1, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, AXI_RESP_SLVERR);
        addr[0] = 32'h0000_0040; we[0] = 1'b1; be[0] = 4'hF; wdata[0] = 32'h5555_AAAA;
        req = 2'b01;
        #1;
        @(negedge clk);
        req = 2'b00;
        wait_rvalid(lat);
        n_cmp++; if (lat !== 3) begin $display("FAIL err_latency: got %0d want 3", lat); n_bad++; end
        n_cmp++; if ({rvalid, err} !== 3'b01_1) begin $display("FAIL err_flag: got %b/%b want 01/1", rvalid, err); n_bad++; end
        @(negedge clk);
        axi.b_resp = AXI_RESP_OKAY;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [1:0] exp_g [4];
`ifdef AXI_MEM_ARBITER_RR_EN
        exp_g = '{2'b10, 2'b01, 2'b10, 2'b01};
`else
        exp_g = '{2'b10, 2'b10, 2'b10, 2'b10};
`endif
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        slave_set(1'b1, 1'b1, 32'hA5A5_0000, 1'b1, 1'b1, 1'b1, AXI_RESP_OKAY);
        addr[0] = 32'h10; addr[1] = 32'h20; we = 2'b00;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (gnt !== exp_g[i]) begin $display("FAIL b2b_gnt%0d: got %b want %b", i, gnt, exp_g[i]); n_bad++; end
            @(negedge clk);
            wait_rvalid(lat);
            n_cmp++; if (lat !== 3 || rvalid !== exp_g[i]) begin
                $display("FAIL b2b_done%0d: got lat %0d rvalid %b want 3/%b", i, lat, rvalid, exp_g[i]); n_bad++; end
            if (i == 3) req = 2'b00;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        logic [1:0] seen;
        slave_set(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, AXI_RESP_OKAY);
        addr[0] = 32'h300; we[0] = 1'b0;
        req = 2'b01;
        #1;
        @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        n_cmp++; if (axi.r_ready !== 1'b1) begin $display("FAIL rmid_in_r: got %b want 1", axi.r_ready); n_bad++; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({axi.ar_valid, axi.r_ready} !== 2'b00) begin
            $display("FAIL rmid_cleared: got %b want 00", {axi.ar_valid, axi.r_ready}); n_bad++; end
        n_cmp++; if (rdata !== 32'h0) begin $display("FAIL rmid_rdata: got %h want 0", rdata); n_bad++; end
        @(negedge clk);
        rst_n = 1'b1;
        axi.r_valid = 1'b1; axi.r_data = 32'h0BAD_F00D;
        seen = 2'b00;
        repeat (3) begin
            @(negedge clk);
            seen = seen | rvalid;
        end
        n_cmp++; if (seen !== 2'b00) begin $display("FAIL rmid_no_pulse: got %b want 00", seen); n_bad++; end
        addr[0] = 32'h304;
        req = 2'b01;
        #1;
        n_cmp++; if (gnt !== 2'b01) begin $display("FAIL rmid_regnt: got %b want 01", gnt); n_bad++; end
        @(negedge clk);
        req = 2'b00;
        n_cmp++; if (axi.ar_addr !== 32'h304) begin $display("FAIL rmid_ar_addr: got %h want 304", axi.ar_addr); n_bad++; end
        wait_rvalid(lat);
        n_cmp++; if ({rvalid, rdata} !== {2'b01, 32'h0BAD_F00D} || lat !== 3) begin
            $display("FAIL rmid_after: got %b/%h lat %0d want 01/0badf00d lat 3", rvalid, rdata, lat); n_bad++; end
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        req   = 2'b00;
        addr  = '0;
        we    = 2'b00;
        be    = '0;
        wdata = '0;
        axi.b_id = '0; axi.b_user = '0;
        axi.r_id = '0; axi.r_last = 1'b1; axi.r_user = '0;
        slave_set(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, AXI_RESP_OKAY);
        @(negedge clk);
        test_reset();
        test_single_read();
        test_read_wait();
        test_single_write();
        test_write_error();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_mem_arbiter.md
AXI_MEM_ARBITER -- requirements
Module: axi_mem_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, AXI and requester data width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 16, AXI ID width; ID carries the granted port index.
REQ-004 SHALL have parameter AXI_USER_WIDTH, default 10, AXI user width; all user fields are driven 0.
REQ-005 SHALL have port clk_i, input, 1, single clock for all logic.
REQ-006 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_i, input, [1:0], request per port (0 = instr, 1 = data).
REQ-008 SHALL have port gnt_o, output, [1:0], one-hot grant pulse per port.
REQ-009 SHALL have port addr_i, input, [1:0][AXI_ADDR_WIDTH], byte address per port.
REQ-010 SHALL have port we_i, input, [1:0], write enable per port.
REQ-011 SHALL have port be_i, input, [1:0][AXI_DATA_WIDTH/8], byte enables per port.
REQ-012 SHALL have port wdata_i, input, [1:0][AXI_DATA_WIDTH], write data per port.
REQ-013 SHALL have port rvalid_o, output, [1:0], completion pulse per port.
REQ-014 SHALL have port rdata_o, output, AXI_DATA_WIDTH, shared read data, valid with rvalid_o.
REQ-015 SHALL have port err_o, output, 1, AXI error flag, valid with rvalid_o.
REQ-016 SHALL have port AXI_Master, AXI_BUS.Master, -, single-beat AXI master toward the BRAM memory.

Function
REQ-017 SHALL implement FSM states IDLE, AR, R, AW_W, B, RESP, with one transaction outstanding at a time.
- IDLE: if any req_i is high, assert gnt_o for the selected port combinationally and latch addr, we, be, wdata and port index.
- On a grant, go to AW_W if we, else to AR.
REQ-018 SHALL drive transaction fields as follows.
- ar_valid is high only in AR and drops the cycle after ar_ready.
- In AW_W, aw_valid and w_valid rise together, and each drops independently after its own ready.
- AW_W exits to B only when both handshakes are done, including the case where both readies arrive in the same cycle.
REQ-019 SHALL hold r_ready high in R and b_ready high in B; the r_valid or b_valid handshake moves the FSM to RESP.
REQ-020 SHALL use these AXI fields: len 0, size log2(AXI_DATA_WIDTH/8), burst INCR (2'b01), w_last 1, id = granted port index, address word-aligned (low bits cleared).
REQ-021 SHALL in RESP pulse rvalid_o[port] for one cycle with registered r_data or zero for writes, set err_o = (resp != OKAY), and return to IDLE.
REQ-022 SHALL give a grant-to-rvalid latency of 3 cycles when the slave readies in zero wait; each slave wait cycle adds exactly one cycle.
REQ-023 SHALL never grant outside IDLE; requesters hold req_i and fields until granted, and withdrawal before grant is unsupported.
REQ-024 SHALL ignore r_last, r_id, b_id and any r_valid or b_valid outside R or B respectively.

Reset
REQ-025 SHALL on rst_ni low immediately return to IDLE and clear all valids, readies, gnt_o, rvalid_o, err_o, rdata_o and latched fields; the RR pointer resets to 0.
REQ-026 SHALL abandon a transaction in flight when reset asserts mid-operation, with no completion pulse after reset release.

Configuration
REQ-027 SHALL, when macro AXI_MEM_ARBITER_RR_EN is defined, resolve simultaneous requests round-robin: the pointer toggles after each grant, and the port not served last wins.
REQ-028 SHALL, without AXI_MEM_ARBITER_RR_EN, resolve simultaneous requests by fixed priority, with port 1 (data) winning.

Structure
REQ-029 SHALL place the state enum, the AXI burst, size and resp constants, and the port-index type in package axi_mem_arbiter_pkg.
REQ-030 SHALL implement the 2-way selection, covering both RR and fixed modes, in sub-module axi_mem_arbiter_sel.

Verification
REQ-031 SHALL cover a single read: req_i=01, addr 0x0000_0104, ar_ready and r_valid zero-wait with r_data 0xDEADBEEF -> ar_addr 0x104, ar_id 0, rvalid_o=01 three cycles after grant, rdata 0xDEADBEEF, err_o 0.
REQ-032 SHALL cover a single write: port 1 writes 0xCAFEF00D with be 4'b0011; aw_ready delayed 2 cycles, w_ready immediate -> w_strb 0011, w_last 1, rvalid_o=10 after b_valid.
REQ-033 SHALL cover simultaneous requests held for 4 transactions -> with RR_EN, grants alternate 10,01,10,01; without it, port 1 takes all four.
REQ-034 SHALL cover an error response: b_resp 2'b10 (SLVERR) on a write -> err_o 1 coincident with rvalid_o.
REQ-035 SHALL cover reset mid-operation: rst_ni asserted while in R -> ar_valid and r_ready are 0 immediately, and the next request after release completes normally.
